fir_mac_engine: RTL and testbench
=================================

Name: fir_mac_engine

Overview:
- Filter compute stage that sits directly downstream of the sample shift-memory.
- Accepts one input sample per transaction and writes it into the sample memory, shifting that memory.
- Walks the tap address across all taps, one per cycle, and multiply-accumulates the stored samples with coefficients from an external combinational-read coefficient ROM.
- Presents one scaled, saturated output sample per input sample on a valid/ready handshake.

Parameters:
- TAPS, 8: number of filter taps; equals the sample memory DEPTH; must be at least 2.
- DATA_W, 8: signed sample width; equals the sample memory WIDTH.
- COEF_W, 8: signed coefficient width.
- OUT_W, 16: signed output width.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream sample available.
- in_data  in  DATA_W  signed input sample.
- in_ready  out  1  engine can accept a sample.
- mem_we  out  1  write-enable to the sample memory (shift plus insert).
- mem_wdata  out  DATA_W  sample written to the memory; always equals in_data.
- tap_addr  out  $clog2(TAPS)  read address shared by the sample memory and the coefficient ROM.
- mem_rdata  in  DATA_W  sample memory read data; combinational from tap_addr.
- coef_data  in  COEF_W  coefficient ROM read data; combinational from tap_addr.
- out_valid  out  1  output sample valid.
- out_data  out  OUT_W  signed filtered output.
- out_ready  in  1  downstream accepts the output.

Behaviour:
- Accumulator width: ACC_W = DATA_W + COEF_W + $clog2(TAPS), signed. All products are signed and sign-extended to ACC_W; no overflow is possible inside the accumulator.
- FSM states: IDLE, MAC, OUT.
- Reset (asynchronous, any state, including mid-MAC or mid-OUT):
  - state goes to IDLE; tap counter, accumulator and out_data are cleared to 0.
  - out_valid=0, mem_we=0, tap_addr=0; in_ready=1 once rst deasserts.
  - The sample memory is cleared by its own reset.
- IDLE:
  - in_ready=1; mem_we = in_valid (combinational).
  - On in_valid at a clock edge: the memory shifts in in_data on that same edge; accumulator <= 0, tap counter <= 0, state goes to MAC.
  - in_valid low: remain in IDLE with no memory write.
- MAC:
  - in_ready=0, mem_we=0, tap_addr = tap counter.
  - Each cycle: acc <= acc + mem_rdata*coef_data; counter increments.
  - Address 0 holds the newest sample, so the tap sequence is y = sum over k of x[n-k]*c[k].
  - After the cycle with counter = TAPS-1: state goes to OUT; out_data <= sat(final_acc >>> OUT_SHIFT) and out_valid <= 1 on the same edge.
  - Exactly TAPS MAC cycles; the counter never wraps past TAPS-1.
- Saturation: the shifted value clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The shift is an arithmetic floor (truncation toward negative infinity), with no rounding.
- OUT:
  - out_valid=1; out_data is held stable while out_ready=0.
  - in_ready=0, so no new sample is accepted and the memory does not shift.
  - On out_ready: out_valid <= 0 and state goes to IDLE. out_data keeps its last value.
  - Next accept is possible one cycle after the output handshake; no overlap.
- Latency: from the accept edge to out_valid asserted is TAPS clock edges.
- Throughput: one sample per TAPS+2 cycles when out_ready is held high.
- in_valid asserted while in_ready=0: ignored. Upstream must hold in_valid and in_data until accepted.

Test Plan:
- Setup for all scenarios: TAPS=4, DATA_W=8, COEF_W=8, OUT_W=16, OUT_SHIFT=0, coefficients {1,2,3,4}, out_ready=1, sample memory model attached.
- Impulse: send 1,0,0,0,0 -> outputs 1,2,3,4,0; each out_valid rises exactly 4 edges after its accept edge.
- Step: send 10 five times -> outputs 10,30,60,100,100.
- Positive saturation: all coefficients 127, inputs 127 x4 -> outputs 16129, 32258, 32767, 32767.
- Negative saturation: all coefficients 127, inputs -128 x3 -> outputs -16256, -32512, -32768.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with in_valid=1 and in_data=55 held during that window -> out_data is stable, in_ready=0 and mem_we=0 throughout; the sample is accepted in the first IDLE cycle after out_ready.
- Reset mid-MAC: assert rst at the 2nd MAC cycle -> out_valid=0, in_ready=1 after release; the next impulse produces 1 (from a cleared history).

Source files
------------

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multiply-accumulate stage of the FIR filter.
// Each accepted sample is shifted into the external sample memory. The engine
// then walks every tap, one per cycle, accumulating sample * coefficient.
// Finally it presents one scaled and saturated result on a valid/ready handshake.
module fir_mac_engine #(
    parameter int TAPS      = 8,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic signed [DATA_W-1:0]  mem_wdata,
    output logic [$clog2(TAPS)-1:0]   tap_addr,
    input  logic signed [DATA_W-1:0]  mem_rdata,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   out_data,
    input  logic                      out_ready
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    // Output clamp limits, expressed in the wider of accumulator/output width
    localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]               state;
    logic [ADDR_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [EXT_W-1:0]  shifted_ext;
    logic signed [OUT_W-1:0]  sat_value;

    // Accepting a sample is the same event as writing it into the shift memory
    assign in_ready  = (state == IDLE) && !rst;
    assign mem_we    = in_ready && in_valid;
    assign mem_wdata = in_data;
    assign tap_addr  = (state == MAC) ? tap_cnt : '0;

    // The accumulator carries log2(TAPS) guard bits, so the sum can never overflow
    assign product     = mem_rdata * coef_data;
    assign acc_next    = acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign shifted     = acc_next >>> OUT_SHIFT;
    assign shifted_ext = EXT_W'(shifted);

    // Clamp the floor-shifted final sum into the signed output range
    always_comb begin
        sat_value = shifted_ext[OUT_W-1:0];
        if (shifted_ext > OUT_MAX) begin
            sat_value = OUT_MAX[OUT_W-1:0];
        end else if (shifted_ext < OUT_MIN) begin
            sat_value = OUT_MIN[OUT_W-1:0];
        end
    end

    // Control FSM: accept a sample, run exactly TAPS MAC cycles, then hold the result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc     <= '0;
                        tap_cnt <= '0;
                        state   <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (tap_cnt == LAST_TAP) begin
                        out_data  <= sat_value;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed test of fir_mac_engine with an attached shift
// memory and coefficient ROM. A transaction-level model predicts the handshake
// timing and filter results, and every cycle is compared against the DUT.
module tb_fir_mac_engine;

    localparam int TAPS      = 4;
    localparam int DATA_W    = 8;
    localparam int COEF_W    = 8;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;
    localparam int ADDR_W    = $clog2(TAPS);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic signed [DATA_W-1:0]  in_data = '0;
    logic                      in_ready;
    logic                      mem_we;
    logic signed [DATA_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0]         tap_addr;
    logic signed [DATA_W-1:0]  mem_rdata;
    logic signed [COEF_W-1:0]  coef_data;
    logic                      out_valid;
    logic signed [OUT_W-1:0]   out_data;
    logic                      out_ready = 1'b1;

    logic signed [DATA_W-1:0]  smem [0:TAPS-1];
    logic signed [COEF_W-1:0]  coef [0:TAPS-1];

    int checks = 0;
    int passes = 0;

    bit m_pending = 1'b0;
    bit m_ov      = 1'b0;
    int m_cnt     = 0;
    int m_next    = 0;
    int m_od      = 0;
    int hist[$];
    int got_q[$];
    int model_q[$];
    int exp_q[$];

    fir_mac_engine #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .tap_addr(tap_addr),
        .mem_rdata(mem_rdata), .coef_data(coef_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Sample shift memory: newest sample at address 0, cleared by its own reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) smem[i] <= '0;
        end else if (mem_we) begin
            for (int i = TAPS - 1; i > 0; i--) smem[i] <= smem[i-1];
            smem[0] <= mem_wdata;
        end
    end

    assign mem_rdata = smem[tap_addr];
    assign coef_data = coef[tap_addr];

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Filter result straight from the definition: sum of x[n-k]*c[k], floor shift, clamp
    function automatic int model_output();
        int acc = 0;
        for (int k = 0; k < hist.size(); k++) acc += hist[k] * int'(coef[k]);
        acc = acc >>> OUT_SHIFT;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    // Per-cycle compare against the model, then advance the model across the next edge
    always @(negedge clk) begin
        if (rst) begin
            m_pending = 1'b0;
            m_ov      = 1'b0;
            m_cnt     = 0;
            m_od      = 0;
            hist.delete();
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_tap_addr", tap_addr, 0);
        end else begin
            check("in_ready", in_ready, !m_pending);
            check("mem_we", mem_we, !m_pending && in_valid);
            if (!m_pending && in_valid) check("mem_wdata", mem_wdata, in_data);
            check("out_valid", out_valid, m_ov);
            check("out_data", out_data, m_od);
            if (out_valid && out_ready) got_q.push_back(int'(out_data));
            if (!m_pending) begin
                if (in_valid) begin
                    hist.push_front(int'(in_data));
                    if (hist.size() > TAPS) void'(hist.pop_back());
                    m_next    = model_output();
                    m_pending = 1'b1;
                    m_cnt     = 0;
                end
            end else if (!m_ov) begin
                m_cnt++;
                if (m_cnt == TAPS) begin
                    m_ov = 1'b1;
                    m_od = m_next;
                    model_q.push_back(m_next);
                end
            end else if (out_ready) begin
                m_ov      = 1'b0;
                m_pending = 1'b0;
            end
        end
    end

    // Offer one sample and hold it until accepted; returns just after the accept edge
    task automatic applyStimulus(input logic signed [DATA_W-1:0] s);
        int waited = 0;
        in_data  = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((out_valid || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (out_valid || !in_ready) check("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Compare DUT outputs and model outputs against hand-computed literals
    task automatic checkOutput(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        check({name, "_model_count"}, model_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_dut[%0d]", name, i), got_q[i], exp_q[i]);
            if (i < model_q.size()) check($sformatf("%s_model[%0d]", name, i), model_q[i], exp_q[i]);
        end
        got_q.delete();
        model_q.delete();
    endtask

    task automatic setCoefs(input int c0, input int c1, input int c2, input int c3);
        coef[0] = COEF_W'(c0);
        coef[1] = COEF_W'(c1);
        coef[2] = COEF_W'(c2);
        coef[3] = COEF_W'(c3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setCoefs(1, 2, 3, 4);
        @(posedge clk);
        #1;
        doReset();
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_tap_addr", tap_addr, 0);
        @(posedge clk);
        #1;

        $display("[TB] impulse");
        applyStimulus(8'sd1);
        for (int i = 0; i < 4; i++) applyStimulus(8'sd0);
        drain();
        exp_q = '{1, 2, 3, 4, 0};
        checkOutput("impulse");

        $display("[TB] step");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'sd10);
        drain();
        exp_q = '{10, 30, 60, 100, 100};
        checkOutput("step");

        $display("[TB] positive saturation");
        setCoefs(127, 127, 127, 127);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(8'sd127);
        drain();
        exp_q = '{16129, 32258, 32767, 32767};
        checkOutput("pos_sat");

        $display("[TB] negative saturation");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(-8'sd128);
        drain();
        exp_q = '{-16256, -32512, -32768};
        checkOutput("neg_sat");

        $display("[TB] backpressure");
        setCoefs(1, 2, 3, 4);
        doReset();
        out_ready = 1'b0;
        applyStimulus(8'sd1);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_out_valid_seen", out_valid, 1);
        end
        @(posedge clk);
        #1;
        in_data  = 8'sd55;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_mem_we", mem_we, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(8'sd55);
        drain();
        exp_q = '{1, 57};
        checkOutput("backpressure");

        $display("[TB] reset during MAC");
        applyStimulus(8'sd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        got_q.delete();
        model_q.delete();
        applyStimulus(8'sd1);
        drain();
        exp_q = '{1};
        checkOutput("mid_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
